// File: rtl/lc3b_types.sv
// Shared LC-3b memory-system types: word and cacheline widths plus the
// state encoding of the L1-to-L2 arbiter.
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_cacheline;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } lc3b_arb_state;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

endpackage

// File: rtl/l2_arbiter.sv
// Two-client arbiter between the I-cache and D-cache and the shared L2.
// One transaction in flight at a time, with an idle guard cycle after every response.
module l2_arbiter
    import lc3b_types::*;
#(
    parameter int FIXED_PRIO = 0
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          i_read,
    input  lc3b_word      i_address,
    output logic          i_resp,
    output lc3b_cacheline i_rdata,

    input  logic          d_read,
    input  logic          d_write,
    input  lc3b_word      d_address,
    input  lc3b_cacheline d_wdata,
    output logic          d_resp,
    output lc3b_cacheline d_rdata,

    output logic          mem_read,
    output logic          mem_write,
    output lc3b_word      mem_address,
    output lc3b_cacheline mem_wdata,
    input  logic          mem_resp,
    input  lc3b_cacheline mem_rdata,

    output lc3b_arb_state state_dbg_o
);

    // Handshake: a client raises read/write and holds it with a stable
    // address until its resp strobe; resp is a one-cycle pulse that mirrors
    // mem_resp, and a request still high the cycle after resp is a new one.

    lc3b_arb_state state_q, state_d;
    logic          last_grant_q, last_grant_d;
    lc3b_word      addr_q, addr_d;
    lc3b_cacheline wdata_q, wdata_d;
    logic          rd_q, rd_d;
    logic          wr_q, wr_d;

    logic          d_req;
    logic          grant_i;
    logic          grant_d;

    assign d_req = d_read | d_write;

    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (i_read && d_req) begin
            if (FIXED_PRIO != 0) begin
                grant_d = 1'b1;
            end else if (last_grant_q == GRANT_D) begin
                grant_i = 1'b1;
            end else begin
                grant_d = 1'b1;
            end
        end else begin
            grant_i = i_read;
            grant_d = d_req;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rd_d         = rd_q;
        wr_d         = wr_q;
        i_resp       = 1'b0;
        d_resp       = 1'b0;

        case (state_q)
            IDLE: begin
                // mem_resp arriving here is spurious and deliberately ignored.
                if (grant_i) begin
                    state_d      = SERVE_I;
                    last_grant_d = GRANT_I;
                    addr_d       = i_address;
                    rd_d         = 1'b1;
                    wr_d         = 1'b0;
                end else if (grant_d) begin
                    state_d      = SERVE_D;
                    last_grant_d = GRANT_D;
                    addr_d       = d_address;
                    wdata_d      = d_wdata;
                    rd_d         = ~d_write;
                    wr_d         = d_write;
                end
            end
            SERVE_I: begin
                i_resp = mem_resp;
                if (mem_resp) begin
                    state_d = IDLE;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                end
            end
            SERVE_D: begin
                d_resp = mem_resp;
                if (mem_resp) begin
                    state_d = IDLE;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                rd_d    = 1'b0;
                wr_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_D;
            addr_q       <= '0;
            wdata_q      <= '0;
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
        end
    end

    assign mem_read    = rd_q;
    assign mem_write   = wr_q;
    assign mem_address = addr_q;
    assign mem_wdata   = wdata_q;
    assign i_rdata     = mem_rdata;
    assign d_rdata     = mem_rdata;
    assign state_dbg_o = state_q;

endmodule

// File: tb/tb_l2_arbiter.sv
// Bench for l2_arbiter: a round-robin instance and a fixed-priority instance
// share client inputs; an L2 model answers whichever instance is selected.
module tb_l2_arbiter;
    import lc3b_types::*;

    localparam int EW = 1 + 1 + 16 + 128;

    logic          clk;
    logic          rst_n;
    logic          sel;
    logic          i_read;
    lc3b_word      i_address;
    logic          d_read;
    logic          d_write;
    lc3b_word      d_address;
    lc3b_cacheline d_wdata;
    logic          mem_resp;
    lc3b_cacheline mem_rdata;

    logic          mem_resp_a, mem_resp_b;
    logic          i_resp_a, d_resp_a, mem_read_a, mem_write_a;
    logic          i_resp_b, d_resp_b, mem_read_b, mem_write_b;
    lc3b_cacheline i_rdata_a, d_rdata_a, mem_wdata_a;
    lc3b_cacheline i_rdata_b, d_rdata_b, mem_wdata_b;
    lc3b_word      mem_address_a, mem_address_b;
    lc3b_arb_state state_a, state_b;

    logic          o_i_resp, o_d_resp, o_mem_read, o_mem_write;
    lc3b_cacheline o_i_rdata, o_d_rdata, o_mem_wdata;
    lc3b_word      o_mem_address;
    lc3b_arb_state o_state;

    logic [EW-1:0] exp_q[$];
    int total;
    int bad;

    assign mem_resp_a = mem_resp & ~sel;
    assign mem_resp_b = mem_resp & sel;

    assign o_i_resp      = sel ? i_resp_b      : i_resp_a;
    assign o_d_resp      = sel ? d_resp_b      : d_resp_a;
    assign o_mem_read    = sel ? mem_read_b    : mem_read_a;
    assign o_mem_write   = sel ? mem_write_b   : mem_write_a;
    assign o_i_rdata     = sel ? i_rdata_b     : i_rdata_a;
    assign o_d_rdata     = sel ? d_rdata_b     : d_rdata_a;
    assign o_mem_wdata   = sel ? mem_wdata_b   : mem_wdata_a;
    assign o_mem_address = sel ? mem_address_b : mem_address_a;
    assign o_state       = sel ? state_b       : state_a;

    l2_arbiter #(.FIXED_PRIO(0)) dut_rr (
        .clk(clk), .rst_n(rst_n),
        .i_read(i_read), .i_address(i_address), .i_resp(i_resp_a), .i_rdata(i_rdata_a),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_resp(d_resp_a), .d_rdata(d_rdata_a),
        .mem_read(mem_read_a), .mem_write(mem_write_a), .mem_address(mem_address_a),
        .mem_wdata(mem_wdata_a), .mem_resp(mem_resp_a), .mem_rdata(mem_rdata),
        .state_dbg_o(state_a)
    );

    l2_arbiter #(.FIXED_PRIO(1)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .i_read(i_read), .i_address(i_address), .i_resp(i_resp_b), .i_rdata(i_rdata_b),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_resp(d_resp_b), .d_rdata(d_rdata_b),
        .mem_read(mem_read_b), .mem_write(mem_write_b), .mem_address(mem_address_b),
        .mem_wdata(mem_wdata_b), .mem_resp(mem_resp_b), .mem_rdata(mem_rdata),
        .state_dbg_o(state_b)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_inputs();
        i_read    = 1'b0;
        i_address = '0;
        d_read    = 1'b0;
        d_write   = 1'b0;
        d_address = '0;
        d_wdata   = '0;
        mem_resp  = 1'b0;
        mem_rdata = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- driver tasks ----------------
    function automatic logic [EW-1:0] mk_exp(input logic cli, input logic wr,
                                             input lc3b_word a, input lc3b_cacheline wd);
        return {cli, wr, a, wd};
    endfunction

    task automatic req_i(input lc3b_word a);
        @(posedge clk);
        #1;
        i_read    = 1'b1;
        i_address = a;
    endtask

    task automatic req_d(input logic rd, input logic wr, input lc3b_word a,
                         input lc3b_cacheline wd);
        @(posedge clk);
        #1;
        d_read    = rd;
        d_write   = wr;
        d_address = a;
        d_wdata   = wd;
    endtask

    // L2 model + scoreboard: waits for a grant, checks it against the head of
    // exp_q, holds it lat cycles, pulses mem_resp, then checks the guard cycle.
    task automatic serve(input int lat, input bit drop_i, input bit drop_d);
        logic [EW-1:0] e;
        logic          e_cli, e_wr;
        lc3b_word      e_addr;
        lc3b_cacheline e_wd, rd, got_rdata;
        int            cyc;
        @(negedge clk);
        cyc = 0;
        while (!(o_mem_read | o_mem_write) && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        total++;
        if (!(o_mem_read | o_mem_write)) begin
            bad++;
            $display("FAIL grant_timeout: no mem_read/mem_write within 20 cycles");
            return;
        end
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_grant: addr=%h with empty expected queue", o_mem_address);
            return;
        end
        e = exp_q.pop_front();
        {e_cli, e_wr, e_addr, e_wd} = e;
        total++;
        if (o_mem_read !== ~e_wr || o_mem_write !== e_wr) begin
            bad++;
            $display("FAIL op: got rd=%b wr=%b, want rd=%b wr=%b", o_mem_read, o_mem_write, ~e_wr, e_wr);
        end
        total++;
        if (o_mem_address !== e_addr) begin
            bad++;
            $display("FAIL grant_addr: got %h want %h (client %0d)", o_mem_address, e_addr, e_cli);
        end
        if (e_wr) begin
            total++;
            if (o_mem_wdata !== e_wd) begin
                bad++;
                $display("FAIL wdata: got %h want %h", o_mem_wdata, e_wd);
            end
        end
        repeat (lat) begin
            @(negedge clk);
            total++;
            if (o_mem_address !== e_addr || (e_wr && o_mem_wdata !== e_wd) ||
                o_mem_read !== ~e_wr || o_mem_write !== e_wr) begin
                bad++;
                $display("FAIL hold_stable: addr=%h wdata=%h rd=%b wr=%b, want addr=%h wdata=%h",
                         o_mem_address, o_mem_wdata, o_mem_read, o_mem_write, e_addr, e_wd);
            end
        end
        @(posedge clk);
        #1;
        rd        = {$urandom, $urandom, $urandom, $urandom};
        mem_resp  = 1'b1;
        mem_rdata = rd;
        @(negedge clk);
        total++;
        if (o_i_resp !== ~e_cli || o_d_resp !== e_cli) begin
            bad++;
            $display("FAIL resp_route: got i_resp=%b d_resp=%b, want i_resp=%b d_resp=%b",
                     o_i_resp, o_d_resp, ~e_cli, e_cli);
        end
        got_rdata = e_cli ? o_d_rdata : o_i_rdata;
        total++;
        if (got_rdata !== rd) begin
            bad++;
            $display("FAIL rdata: got %h want %h", got_rdata, rd);
        end
        @(posedge clk);
        #1;
        mem_resp = 1'b0;
        if (drop_i) i_read = 1'b0;
        if (drop_d) begin
            d_read  = 1'b0;
            d_write = 1'b0;
        end
        @(negedge clk);
        total++;
        if (o_mem_read !== 1'b0 || o_mem_write !== 1'b0 || o_state !== IDLE) begin
            bad++;
            $display("FAIL guard_cycle: got rd=%b wr=%b state=%0d, want 0 0 IDLE",
                     o_mem_read, o_mem_write, o_state);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        sel = 1'b0;
        rst_n = 1'b0;
        clear_inputs();
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if (o_mem_read !== 1'b0 || o_mem_write !== 1'b0 || o_mem_address !== 16'h0 ||
            o_mem_wdata !== 128'h0 || o_i_resp !== 1'b0 || o_d_resp !== 1'b0 || o_state !== IDLE) begin
            bad++;
            $display("FAIL reset_outputs: rd=%b wr=%b addr=%h wdata=%h iresp=%b dresp=%b state=%0d, want all 0",
                     o_mem_read, o_mem_write, o_mem_address, o_mem_wdata, o_i_resp, o_d_resp, o_state);
        end
        rst_n = 1'b1;
        req_i(16'h1230);
        exp_q.push_back(mk_exp(1'b0, 1'b0, 16'h1230, '0));
        @(negedge clk);
        total++;
        if (o_mem_read !== 1'b0) begin
            bad++;
            $display("FAIL grant_early: mem_read=%b in request cycle, want 0", o_mem_read);
        end
        @(negedge clk);
        total++;
        if (o_mem_read !== 1'b1 || o_mem_address !== 16'h1230) begin
            bad++;
            $display("FAIL grant_latency: rd=%b addr=%h one cycle later, want 1 1230", o_mem_read, o_mem_address);
        end
        serve(1, 1'b1, 1'b0);
    endtask

    task automatic test_simultaneous();
        do_reset();
        @(posedge clk);
        #1;
        i_read    = 1'b1;
        i_address = 16'h0100;
        d_read    = 1'b1;
        d_address = 16'h0200;
        exp_q.push_back(mk_exp(1'b0, 1'b0, 16'h0100, '0));
        exp_q.push_back(mk_exp(1'b1, 1'b0, 16'h0200, '0));
        serve(2, 1'b1, 1'b0);
        serve(0, 1'b0, 1'b1);
    endtask

    task automatic test_write_latch();
        do_reset();
        req_d(1'b1, 1'b1, 16'h4440, 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF);
        exp_q.push_back(mk_exp(1'b1, 1'b1, 16'h4440, 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF));
        @(posedge clk);
        #1;
        d_wdata   = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
        d_address = 16'h9990;
        serve(3, 1'b0, 1'b1);
    endtask

    task automatic test_fairness_rr();
        do_reset();
        @(posedge clk);
        #1;
        i_read    = 1'b1;
        i_address = 16'h1000;
        d_read    = 1'b1;
        d_address = 16'h2000;
        for (int k = 0; k < 6; k++)
            exp_q.push_back(mk_exp(k[0], 1'b0, k[0] ? 16'h2000 : 16'h1000, '0));
        for (int k = 0; k < 5; k++)
            serve($urandom_range(0, 3), 1'b0, 1'b0);
        serve(1, 1'b1, 1'b1);
    endtask

    task automatic test_fixed_prio();
        do_reset();
        sel = 1'b1;
        @(posedge clk);
        #1;
        i_read    = 1'b1;
        i_address = 16'h0A00;
        d_read    = 1'b1;
        d_address = 16'h0D00;
        for (int k = 0; k < 3; k++)
            exp_q.push_back(mk_exp(1'b1, 1'b0, 16'h0D00, '0));
        exp_q.push_back(mk_exp(1'b0, 1'b0, 16'h0A00, '0));
        serve(1, 1'b0, 1'b0);
        serve(0, 1'b0, 1'b0);
        serve(2, 1'b0, 1'b1);
        serve(1, 1'b1, 1'b0);
        sel = 1'b0;
        do_reset();
    endtask

    task automatic test_spurious();
        do_reset();
        @(posedge clk);
        #1;
        mem_resp  = 1'b1;
        mem_rdata = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        total++;
        if (o_i_resp !== 1'b0 || o_d_resp !== 1'b0) begin
            bad++;
            $display("FAIL spurious_resp: i_resp=%b d_resp=%b, want 0 0", o_i_resp, o_d_resp);
        end
        @(posedge clk);
        #1;
        mem_resp = 1'b0;
        @(negedge clk);
        total++;
        if (o_mem_read !== 1'b0 || o_mem_write !== 1'b0 || o_state !== IDLE) begin
            bad++;
            $display("FAIL spurious_state: rd=%b wr=%b state=%0d, want 0 0 IDLE", o_mem_read, o_mem_write, o_state);
        end
    endtask

    task automatic reset_mid(input lc3b_arb_state want_state);
        int cyc;
        cyc = 0;
        @(negedge clk);
        while (o_state !== want_state && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        total++;
        if (o_state !== want_state) begin
            bad++;
            $display("FAIL mid_grant_timeout: state=%0d want %0d", o_state, want_state);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (o_mem_read !== 1'b0 || o_mem_write !== 1'b0 || o_mem_address !== 16'h0 ||
            o_mem_wdata !== 128'h0 || o_state !== IDLE) begin
            bad++;
            $display("FAIL async_reset: rd=%b wr=%b addr=%h wdata=%h state=%0d, want all 0 IDLE",
                     o_mem_read, o_mem_write, o_mem_address, o_mem_wdata, o_state);
        end
        clear_inputs();
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_d(1'b0, 1'b1, 16'h5550, 128'hCAFE);
        reset_mid(SERVE_D);
        req_i(16'h0ABC);
        reset_mid(SERVE_I);
        // last_grant must be back to D, so I wins this tie
        @(posedge clk);
        #1;
        i_read    = 1'b1;
        i_address = 16'h0111;
        d_read    = 1'b1;
        d_address = 16'h0222;
        exp_q.push_back(mk_exp(1'b0, 1'b0, 16'h0111, '0));
        exp_q.push_back(mk_exp(1'b1, 1'b0, 16'h0222, '0));
        serve(1, 1'b1, 1'b0);
        serve(1, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        logic          cli, wr;
        lc3b_word      a;
        lc3b_cacheline wd;
        do_reset();
        for (int k = 0; k < 10; k++) begin
            cli = 1'($urandom_range(0, 1));
            wr  = cli & 1'($urandom_range(0, 1));
            a   = 16'($urandom_range(0, 16'hFFFF)) & 16'hFFF0;
            wd  = {$urandom, $urandom, $urandom, $urandom};
            if (cli) begin
                req_d(~wr, wr, a, wd);
                exp_q.push_back(mk_exp(1'b1, wr, a, wd));
                serve($urandom_range(0, 4), 1'b0, 1'b1);
            end else begin
                req_i(a);
                exp_q.push_back(mk_exp(1'b0, 1'b0, a, '0));
                serve($urandom_range(0, 4), 1'b1, 1'b0);
            end
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL leftover: %0d expected grants never seen, want 0", exp_q.size());
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        sel   = 1'b0;
        rst_n = 1'b0;
        clear_inputs();
        test_reset();
        test_simultaneous();
        test_write_latch();
        test_fairness_rr();
        test_fixed_prio();
        test_spurious();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/l2_arbiter.md
# l2_arbiter

Two-client arbiter between the split L1 caches and the shared `l2_cache`. It accepts cacheline requests from the instruction cache (read-only) and the data cache (read/write) and grants one at a time. It drives the L2 request side (`mem_read`, `mem_write`, `mem_address`, `mem_wdata`) as the initiator. It routes `mem_resp` and `mem_rdata` back to the granted client only.

## Interface
Parameters:
- `FIXED_PRIO`, default 0: 0 = round-robin between I and D; 1 = D always wins a tie.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `i_read`  in  1  I-cache cacheline read request; held until `i_resp`
- `i_address`  in  `lc3b_word`  I-cache line address
- `i_resp`  out  1  I-cache response strobe
- `i_rdata`  out  `lc3b_cacheline`  I-cache read data
- `d_read`, `d_write`  in  1 each  D-cache request; held until `d_resp`
- `d_address`  in  `lc3b_word`  D-cache line address
- `d_wdata`  in  `lc3b_cacheline`  D-cache write data
- `d_resp`  out  1  D-cache response strobe
- `d_rdata`  out  `lc3b_cacheline`  D-cache read data
- `mem_read`, `mem_write`  out  1 each  L2 request
- `mem_address`  out  `lc3b_word`  L2 address
- `mem_wdata`  out  `lc3b_cacheline`  L2 write data
- `mem_resp`  in  1  L2 response strobe
- `mem_rdata`  in  `lc3b_cacheline`  L2 read data

## Operation
- States: IDLE, SERVE_I, SERVE_D. Reset state is IDLE.
- `last_grant` register (1 bit, 0 = I, 1 = D). Reset value is 1, so I wins the first tie.
- In IDLE, with `d_req = d_read | d_write`:
  - Only one request pending: grant that client.
  - Both pending and `FIXED_PRIO=0`: grant the client that is not `last_grant`.
  - Both pending and `FIXED_PRIO=1`: grant D.
  - No request: stay in IDLE.
- At the grant edge:
  - Latch the client's address (and `d_wdata` for D) into holding registers.
  - Latch op: for D, `d_write` takes precedence if both `d_read` and `d_write` are high; I is always a read.
  - Set `last_grant`.
  - Move to SERVE_x.
- In SERVE_x:
  - `mem_read`/`mem_write` reflect the latched op.
  - `mem_address` and `mem_wdata` come from the holding registers and stay stable for the whole transaction, even if client inputs change.
- `mem_resp` in SERVE_x:
  - `x_resp = mem_resp` combinationally; the other client's resp stays 0.
  - Next state is IDLE.
- `i_rdata` and `d_rdata` both pass `mem_rdata` through. They are valid only when the matching resp is high.
- `mem_resp` in IDLE is spurious: ignore it, and assert no client resp.

## Timing
- Reset values: `mem_read`=0, `mem_write`=0, `mem_address`=0, `mem_wdata`=0, `i_resp`=0, `d_resp`=0, state=IDLE, `last_grant`=1.
- Grant latency:
  - Request visible in IDLE in cycle T.
  - `mem_read`/`mem_write` high in cycle T+1, driven from registers.
- Response path is zero-latency: client resp is high in the same cycle as `mem_resp`.
- Turnaround:
  - `mem_resp` in cycle N.
  - `mem_read`/`mem_write` low in cycle N+1; this IDLE guard cycle lets the L2 controller return to idle.
  - Next grant issues in cycle N+2.
- Clients deassert their request the cycle after resp. A client still requesting in N+1 is treated as a new request.
- Reset asserted mid-transaction: immediately (asynchronously) force IDLE, clear all outputs and restore `last_grant`=1. The L2 is reset alongside.
- A request arriving while the other client is being served waits. With round-robin it is served next, so the maximum wait is one transaction plus guard cycles.

## Structure
- Add `lc3b_arb_state` (enum IDLE/SERVE_I/SERVE_D) to `lc3b_types`.
- Reuse the existing `lc3b_word` and `lc3b_cacheline` types.
- Single module, no sub-modules:
  - Next-state/grant logic in `always_comb`.
  - State, `last_grant` and holding registers in one `always_ff @(posedge clk or negedge rst_n)`.

## Test plan
- Reset: `rst_n`=0 with all inputs X-free → all outputs 0. Release, assert `i_read` @0x1230 → `mem_read`=1, `mem_address`=0x1230 exactly one cycle later.
- Simultaneous requests: `i_read`@0x0100 and `d_read`@0x0200 both high in IDLE, `FIXED_PRIO=0`.
  - I is served first.
  - On `mem_resp`: `i_resp`=1 with `i_rdata`=`mem_rdata`, `d_resp`=0.
  - After one guard cycle, `mem_address`=0x0200.
- Write latching: `d_write` with `d_wdata`=128'hDEAD…BEEF @0x4440, then change `d_wdata` mid-transaction → `mem_wdata` stays at the latched value until `mem_resp`. `d_read` and `d_write` both high → `mem_write`=1, `mem_read`=0.
- Fairness: both clients request continuously for 6 transactions → grants alternate I,D,I,D,I,D. With `FIXED_PRIO=1` → D,D,D… and I is starved.
- Spurious and mid-operation events:
  - `mem_resp` pulsed in IDLE → no client resp.
  - `rst_n` low during SERVE_D → `mem_write` drops in the same cycle without a clock edge; state returns to IDLE.
